// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module   : alu_multicycle
//  Brief    : ALU with single-cycle logic/arith ops and a shift-add multiply
//  Revision : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_MUL  = 1'b1;

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;
    localparam logic [3:0] c_OP_NOR = 4'b1100;
    localparam logic [3:0] c_OP_MUL = 4'b1000;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_prod;

    logic               w_sub;
    logic [WIDTH-1:0]   w_b_op;
    logic [WIDTH:0]     w_sum;
    logic               w_add_ovf;
    logic [WIDTH-1:0]   w_res;
    logic               w_cout;
    logic               w_ovf;
    logic [WIDTH:0]     w_step;
    logic [2*WIDTH-1:0] w_prod_next;

    // One shared adder serves ADD, SUB and SLT.
    assign w_sub     = (ctrl_i == c_OP_SUB) || (ctrl_i == c_OP_SLT);
    assign w_b_op    = w_sub ? ~src2_i : src2_i;
    assign w_sum     = {1'b0, src1_i} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_sub};
    assign w_add_ovf = (src1_i[WIDTH-1] == w_b_op[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != src1_i[WIDTH-1]);

    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        case (ctrl_i)
            c_OP_AND: w_res = src1_i & src2_i;
            c_OP_OR:  w_res = src1_i | src2_i;
            c_OP_NOR: w_res = ~(src1_i | src2_i);
            c_OP_ADD, c_OP_SUB: begin
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = w_add_ovf;
            end
            c_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_add_ovf};
            default:  w_res = '0;
        endcase
    end

    // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    assign w_step      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
    assign w_prod_next = {w_step, r_prod[WIDTH-1:1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_S_IDLE;
            r_cnt      <= '0;
            r_a        <= '0;
            r_prod     <= '0;
            result_o   <= '0;
            zero_o     <= 1'b1;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start_i) begin
                        if (ctrl_i == c_OP_MUL) begin
                            r_state <= c_S_MUL;
                            busy_o  <= 1'b1;
                            r_a     <= src1_i;
                            r_prod  <= {{WIDTH{1'b0}}, src2_i};
                            r_cnt   <= '0;
                        end else begin
                            result_o   <= w_res;
                            zero_o     <= (w_res == '0);
                            cout_o     <= w_cout;
                            overflow_o <= w_ovf;
                            done_o     <= 1'b1;
                        end
                    end
                end
                c_S_MUL: begin
                    r_prod <= w_prod_next;
                    if (r_cnt == c_LAST) begin
                        r_state    <= c_S_IDLE;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                        result_o   <= w_prod_next[WIDTH-1:0];
                        zero_o     <= (w_prod_next[WIDTH-1:0] == '0);
                        cout_o     <= 1'b0;
                        overflow_o <= |w_prod_next[2*WIDTH-1:WIDTH];
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_multicycle
//  Brief    : Self-checking bench for alu_multicycle at WIDTH=32 and WIDTH=8
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

    localparam logic [3:0] c_AND = 4'b0000;
    localparam logic [3:0] c_OR  = 4'b0001;
    localparam logic [3:0] c_ADD = 4'b0010;
    localparam logic [3:0] c_SUB = 4'b0110;
    localparam logic [3:0] c_SLT = 4'b0111;
    localparam logic [3:0] c_NOR = 4'b1100;
    localparam logic [3:0] c_MUL = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start32 = 1'b0;
    logic        start8 = 1'b0;
    logic [3:0]  ctrl = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic [31:0] res32;
    logic [7:0]  res8;
    logic        z32, c32, v32, busy32, done32;
    logic        z8, c8, v8, busy8, done8;

    int sel = 32;
    int n_tests = 0;
    int n_fail = 0;

    logic [31:0] o_res;
    logic        o_z, o_c, o_v, o_busy, o_done;
    assign o_res  = (sel == 8) ? {24'd0, res8} : res32;
    assign o_z    = (sel == 8) ? z8 : z32;
    assign o_c    = (sel == 8) ? c8 : c32;
    assign o_v    = (sel == 8) ? v8 : v32;
    assign o_busy = (sel == 8) ? busy8 : busy32;
    assign o_done = (sel == 8) ? done8 : done32;

    alu_multicycle #(.WIDTH(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .start_i(start32),
        .src1_i(a), .src2_i(b), .ctrl_i(ctrl),
        .result_o(res32), .zero_o(z32), .cout_o(c32), .overflow_o(v32),
        .busy_o(busy32), .done_o(done32)
    );

    alu_multicycle #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8),
        .src1_i(a[7:0]), .src2_i(b[7:0]), .ctrl_i(ctrl),
        .result_o(res8), .zero_o(z8), .cout_o(c8), .overflow_o(v8),
        .busy_o(busy8), .done_o(done8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (width %0d): got %0h expected %0h", tag, sel, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on masked operands.
    task automatic ref_op(input int w, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output logic z, output logic c, output logic v);
        longint unsigned mask, ua, ub, p;
        longint sa, sb, s, smax, smin;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, x} & mask;
        ub   = {32'd0, y} & mask;
        sa   = (((ua >> (w - 1)) & 64'd1) != 0) ? longint'(ua) - longint'(mask + 64'd1) : longint'(ua);
        sb   = (((ub >> (w - 1)) & 64'd1) != 0) ? longint'(ub) - longint'(mask + 64'd1) : longint'(ub);
        smax = longint'(mask >> 1);
        smin = -smax - 1;
        c = 1'b0;
        v = 1'b0;
        case (op)
            c_AND: p = ua & ub;
            c_OR:  p = ua | ub;
            c_NOR: p = ~(ua | ub);
            c_ADD: begin
                p = ua + ub;
                c = ((p >> w) & 64'd1) != 0;
                s = sa + sb;
                v = (s > smax) || (s < smin);
            end
            c_SUB: begin
                p = ua - ub;
                c = (ua >= ub);
                s = sa - sb;
                v = (s > smax) || (s < smin);
            end
            c_SLT: p = (sa < sb) ? 64'd1 : 64'd0;
            c_MUL: begin
                p = ua * ub;
                v = (p >> w) != 0;
            end
            default: p = 64'd0;
        endcase
        res = 32'(p & mask);
        z   = (res == 32'd0);
    endtask

    task automatic set_start(input int w, input logic val);
        if (w == 8) start8 = val;
        else        start32 = val;
    endtask

    // Issue one op; optionally poke an ADD start at cycle inject_at while the op runs.
    task automatic run_op(input int w, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int inject_at);
        logic [31:0] er;
        logic ez, ec, ev;
        int cyc, busy_cnt;
        ref_op(w, op, x, y, er, ez, ec, ev);
        sel = w;
        @(negedge clk);
        ctrl = op; a = x; b = y;
        set_start(w, 1'b1);
        @(posedge clk); #1;
        set_start(w, 1'b0);
        cyc = 1;
        busy_cnt = 0;
        while (!o_done && cyc < 200) begin
            if (o_busy) busy_cnt++;
            if (cyc == inject_at) begin
                @(negedge clk);
                ctrl = c_ADD; a = 32'd1; b = 32'd2;
                set_start(w, 1'b1);
                @(posedge clk); #1;
                set_start(w, 1'b0);
            end else begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        check("latency", cyc, (op == c_MUL) ? w + 1 : 1);
        check("busy_cycles", busy_cnt, (op == c_MUL) ? w : 0);
        check("done", o_done, 1);
        check("result", o_res, er);
        check("zero", o_z, ez);
        check("cout", o_c, ec);
        check("overflow", o_v, ev);
        @(posedge clk); #1;
        check("done_pulse", o_done, 0);
        check("result_hold", o_res, er);
    endtask

    task automatic rst_mid_mul(input int w);
        int seen;
        sel = w;
        @(negedge clk);
        ctrl = c_MUL; a = 32'h0000_1234; b = 32'h0000_0057;
        set_start(w, 1'b1);
        @(posedge clk); #1;
        set_start(w, 1'b0);
        repeat ((w == 8) ? 3 : 9) @(posedge clk);
        #1;
        check("busy_before_rst", o_busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_result", o_res, 0);
        check("rst_zero", o_z, 1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (o_done || o_busy) seen++;
        end
        check("abort_no_done", seen, 0);
        run_op(w, c_OR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 0);
    endtask

    task automatic back_to_back(input int w);
        sel = w;
        @(negedge clk);
        ctrl = c_ADD; a = 32'd1; b = 32'd2;
        set_start(w, 1'b1);
        @(posedge clk); #1;
        check("b2b_done1", o_done, 1);
        check("b2b_res1", o_res, 3);
        ctrl = c_NOR; a = 32'd0; b = 32'd0;
        @(posedge clk); #1;
        set_start(w, 1'b0);
        check("b2b_done2", o_done, 1);
        check("b2b_res2", o_res, (w == 8) ? 32'h0000_00FF : 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("b2b_done3", o_done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops [8];
        int widths [2];
        widths[0] = 32;
        widths[1] = 8;
        ops[0] = c_AND; ops[1] = c_OR; ops[2] = c_ADD; ops[3] = c_SUB;
        ops[4] = c_SLT; ops[5] = c_NOR; ops[6] = c_MUL; ops[7] = 4'd0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            sel = widths[i];
            check("reset_result", o_res, 0);
            check("reset_zero", o_z, 1);
            check("reset_flags", {o_c, o_v, o_busy, o_done}, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 2; i++) begin
            int w;
            w = widths[i];
            run_op(w, c_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0);
            run_op(w, c_ADD, 32'h0000_007F, 32'h0000_0001, 0);
            run_op(w, c_SUB, 32'd5, 32'd5, 0);
            run_op(w, c_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 0);
            run_op(w, c_MUL, 32'h0001_0000, 32'h0001_0000, 5);
            run_op(w, c_MUL, 32'h0000_FFFF, 32'h0000_FFFF, 0);
            run_op(w, c_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
            run_op(w, 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0);
            rst_mid_mul(w);
            back_to_back(w);
            repeat (40) begin
                ops[7] = 4'($urandom_range(0, 15));
                run_op(w, ops[$urandom_range(0, 7)], $urandom, $urandom, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the datapath width; legal values 4..64.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 start_i  input  1  SHALL request an operation; sampled only when busy_o=0.
REQ-005 src1_i  input  WIDTH  SHALL carry operand A, captured on accepted start.
REQ-006 src2_i  input  WIDTH  SHALL carry operand B, captured on accepted start.
REQ-007 ctrl_i  input  4  SHALL carry the opcode, captured on accepted start.
REQ-008 result_o  output  WIDTH  SHALL carry the registered result.
REQ-009 zero_o  output  1  SHALL indicate result_o==0, registered with result_o.
REQ-010 cout_o  output  1  SHALL carry the carry-out flag, registered.
REQ-011 overflow_o  output  1  SHALL carry the overflow flag, registered.
REQ-012 busy_o  output  1  SHALL be high while a multiply is in progress.
REQ-013 done_o  output  1  SHALL pulse high for one cycle when result_o/flags update.

Function
REQ-014 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MUL; any other code -> result 0, all flags 0, done_o after 1 cycle.
REQ-015 FSM states SHALL be IDLE and MUL; start_i with busy_o=0 and ctrl_i!=1000 stays in IDLE; with ctrl_i=1000 goes IDLE->MUL.
REQ-016 Single-cycle ops SHALL update result_o, flags and assert done_o on the edge accepting start (visible in the following cycle): latency 1.
REQ-017 ADD/SUB/SLT SHALL compute A + (B or ~B) + cin, with cin=1 and B inverted for SUB/SLT; one shared WIDTH+1-bit adder.
REQ-018 cout_o SHALL be adder bit WIDTH for ADD/SUB (SUB: 1 = no borrow), else 0.
REQ-019 overflow_o SHALL be signed overflow (operand signs equal, sum sign differs) for ADD/SUB, else 0 except REQ-022.
REQ-020 SLT SHALL return 1 when A<B signed (sum MSB XOR overflow), else 0, zero-extended to WIDTH.
REQ-021 MUL SHALL be unsigned shift-add, one multiplier bit per cycle, exactly WIDTH cycles in MUL; busy_o=1 for those WIDTH cycles; done_o pulses in the cycle after leaving MUL; latency WIDTH+1 from accepted start.
REQ-022 MUL result_o SHALL be the low WIDTH bits of the 2*WIDTH product; overflow_o=1 iff the upper WIDTH bits are nonzero; cout_o=0.
REQ-023 start_i while busy_o=1 SHALL be ignored; operands, opcode and progress unaffected.
REQ-024 start_i in a cycle where done_o=1 SHALL be accepted (back-to-back issue, no bubble).
REQ-025 result_o and flags SHALL hold their last values between done_o pulses, including while busy_o=1.
REQ-026 Iteration counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL NOT wrap before MUL exit.

Reset
REQ-027 rst_i=1 SHALL, at the next edge, force IDLE and result_o=0, zero_o=1, cout_o=0, overflow_o=0, busy_o=0, done_o=0, clearing counter and product registers.
REQ-028 rst_i SHALL take priority over start_i and abort an in-progress MUL with no done_o pulse.

Verification
REQ-029 ADD 0x7FFFFFFF+0x00000001 -> next cycle result_o=0x80000000, overflow_o=1, cout_o=0, zero_o=0, done_o=1 for one cycle.
REQ-030 SUB 5-5 -> result_o=0, zero_o=1, cout_o=1, overflow_o=0; then SLT 0xFFFFFFFF vs 0x00000001 -> result_o=1.
REQ-031 MUL 0x00010000*0x00010000 -> busy_o high 32 cycles, done_o on cycle 33, result_o=0, zero_o=1, overflow_o=1; a start_i pulse (ADD) mid-multiply changes nothing.
REQ-032 MUL 0x0000FFFF*0x0000FFFF -> result_o=0xFFFE0001, overflow_o=0; MUL 0xFFFFFFFF*0xFFFFFFFF -> result_o=0x00000001, overflow_o=1.
REQ-033 rst_i asserted at MUL cycle 10 -> next cycle busy_o=0, done_o=0, result_o=0, zero_o=1; subsequent OR 0xF0F0F0F0|0x0F0F0F0F -> 0xFFFFFFFF in 1 cycle.
REQ-034 start_i held high across done_o with ADD 1+2 then NOR 0,0 -> done_o high two consecutive cycles, results 0x00000003 then 0xFFFFFFFF; repeat all at WIDTH=8.
